// File: rtl/osd_pkg.sv
// Shared character constants, FSM states and parse phases for the OSD decimal reader.
package osd_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_NUL   = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    EVAL,
    FINISH
  } osd_rd_state_t;

  // SP: only spaces so far, SG: sign consumed, DG: at least one digit consumed
  typedef enum logic [1:0] {
    PH_SP,
    PH_SG,
    PH_DG
  } osd_phase_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASCII_0) && (c <= ASCII_9);
  endfunction

endpackage

// File: rtl/osd_dec_digit_acc.sv
// Combinational decimal digit accumulator: next = acc*10 + digit, flagged when the
// magnitude exceeds the signed range selected by neg.
module osd_dec_digit_acc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [3:0]       digit,
  input  logic             neg,
  output logic [WIDTH-1:0] next_acc,
  output logic             ovf
);

  // Four guard bits hold acc*10+9 for any acc up to 2^(WIDTH-1)
  localparam int XW = WIDTH + 4;

  logic [XW-1:0] acc_x;
  logic [XW-1:0] sum_x;
  logic [XW-1:0] limit_x;

  always_comb begin
    acc_x   = {4'b0000, acc};
    sum_x   = (acc_x << 3) + (acc_x << 1) + {{(XW-4){1'b0}}, digit};
    limit_x = XW'(1) << (WIDTH - 1);
    if (!neg) begin
      limit_x = limit_x - XW'(1);
    end
    ovf      = (sum_x > limit_x);
    next_acc = sum_x[WIDTH-1:0];
  end

endmodule

// File: rtl/osd_sdec_reader.sv
// Reads a signed decimal number out of OSD character RAM: skips leading spaces,
// takes one optional sign, accumulates digits and reports value, length and error.
module osd_sdec_reader
  import osd_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  input  logic [15:0]      base_addr,
  input  logic [7:0]       max_len,
  output logic             char_re,
  output logic [15:0]      char_addr,
  input  logic [7:0]       char_rdata,
  output logic [WIDTH-1:0] value,
  output logic [7:0]       n_chars
);

  localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [1:0]       LAT_INIT = 2'(RD_LAT - 1);

  osd_rd_state_t    state_q, state_d;
  osd_phase_t       phase_q, phase_d;
  logic [15:0]      cursor_q, cursor_d;
  logic [7:0]       remaining_q, remaining_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             neg_q, neg_d;
  logic             digit_seen_q, digit_seen_d;
  logic [1:0]       lat_q, lat_d;
  logic [7:0]       n_chars_q, n_chars_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             error_q, error_d;

  logic [WIDTH-1:0] digit_acc;
  logic             digit_ovf;
  logic             consume;
  logic             finish_parse;

  osd_dec_digit_acc #(
    .WIDTH(WIDTH)
  ) u_digit_acc (
    .acc     (acc_q),
    .digit   (char_rdata[3:0]),
    .neg     (neg_q),
    .next_acc(digit_acc),
    .ovf     (digit_ovf)
  );

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    cursor_d     = cursor_q;
    remaining_d  = remaining_q;
    acc_d        = acc_q;
    neg_d        = neg_q;
    digit_seen_d = digit_seen_q;
    lat_d        = lat_q;
    n_chars_d    = n_chars_q;
    value_d      = value_q;
    error_d      = error_q;
    consume      = 1'b0;
    finish_parse = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cursor_d     = base_addr;
          remaining_d  = max_len;
          acc_d        = '0;
          neg_d        = 1'b0;
          digit_seen_d = 1'b0;
          phase_d      = PH_SP;
          n_chars_d    = 8'd0;
          error_d      = 1'b0;
          if (max_len == 8'd0) begin
            error_d = 1'b1;
            value_d = '0;
            state_d = FINISH;
          end else begin
            state_d = FETCH;
          end
        end
      end

      FETCH: begin
        lat_d   = LAT_INIT;
        state_d = (RD_LAT > 1) ? WAIT : EVAL;
      end

      WAIT: begin
        if (lat_q <= 2'd1) begin
          state_d = EVAL;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end

      EVAL: begin
        // An overflowing digit still counts as consumed but ends the parse saturated
        if (char_rdata == ASCII_NUL) begin
          finish_parse = 1'b1;
        end else if (is_digit(char_rdata)) begin
          if (digit_ovf) begin
            n_chars_d = n_chars_q + 8'd1;
            error_d   = 1'b1;
            value_d   = neg_q ? MIN_NEG : MAX_POS;
            state_d   = FINISH;
          end else begin
            acc_d        = digit_acc;
            digit_seen_d = 1'b1;
            phase_d      = PH_DG;
            consume      = 1'b1;
          end
        end else if ((char_rdata == ASCII_SPACE) && (phase_q == PH_SP)) begin
          consume = 1'b1;
        end else if (((char_rdata == ASCII_PLUS) || (char_rdata == ASCII_MINUS)) &&
                     (phase_q == PH_SP)) begin
          neg_d   = (char_rdata == ASCII_MINUS);
          phase_d = PH_SG;
          consume = 1'b1;
        end else begin
          finish_parse = 1'b1;
        end

        if (consume) begin
          cursor_d    = cursor_q + 16'd1;
          n_chars_d   = n_chars_q + 8'd1;
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) begin
            finish_parse = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end

        // Result is registered on the way into FINISH so it is valid with done
        if (finish_parse) begin
          state_d = FINISH;
          error_d = !digit_seen_d;
          if (!digit_seen_d) begin
            value_d = '0;
          end else begin
            value_d = neg_d ? -acc_d : acc_d;
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_q      <= PH_SP;
      cursor_q     <= 16'd0;
      remaining_q  <= 8'd0;
      acc_q        <= '0;
      neg_q        <= 1'b0;
      digit_seen_q <= 1'b0;
      lat_q        <= 2'd0;
      n_chars_q    <= 8'd0;
      value_q      <= '0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cursor_q     <= cursor_d;
      remaining_q  <= remaining_d;
      acc_q        <= acc_d;
      neg_q        <= neg_d;
      digit_seen_q <= digit_seen_d;
      lat_q        <= lat_d;
      n_chars_q    <= n_chars_d;
      value_q      <= value_d;
      error_q      <= error_d;
    end
  end

  assign busy      = (state_q == FETCH) || (state_q == WAIT) || (state_q == EVAL);
  assign done      = (state_q == FINISH);
  assign char_re   = (state_q == FETCH);
  assign char_addr = cursor_q;
  assign value     = value_q;
  assign error     = error_q;
  assign n_chars   = n_chars_q;

endmodule

// File: tb/tb_osd_sdec_reader.sv
// Bench for osd_sdec_reader: three instances (W32/L1, W32/L3, W8/L1) on a shared
// character RAM model, table vectors, corner sequences and random strings vs a model.
module tb_osd_sdec_reader;

  typedef struct {
    int    d;
    int    base;
    int    ml;
    string text;
    longint expVal;
    longint expErr;
    longint expN;
    longint expReads;
  } vec_t;

  typedef struct {
    longint val;
    longint err;
    longint nch;
    longint reads;
    longint cyc;
    longint extra;
    longint busyAtDone;
    logic [15:0] a0;
    logic [15:0] a1;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start [3];
  logic [15:0] base_addr;
  logic [7:0]  max_len;
  logic        busy [3];
  logic        done [3];
  logic        error [3];
  logic        char_re [3];
  logic [15:0] char_addr [3];
  logic [7:0]  char_rdata [3];
  logic [7:0]  n_chars [3];
  logic [31:0] val_a;
  logic [31:0] val_b;
  logic [7:0]  val_c;

  logic [7:0]  mem [65536];
  logic [15:0] pa [3][3];
  logic        pv [3][3];

  int nChecks = 0;
  int nFail = 0;

  always #5 clk = ~clk;

  osd_sdec_reader #(.WIDTH(32), .RD_LAT(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .error(error[0]), .base_addr(base_addr), .max_len(max_len), .char_re(char_re[0]),
    .char_addr(char_addr[0]), .char_rdata(char_rdata[0]), .value(val_a), .n_chars(n_chars[0])
  );

  osd_sdec_reader #(.WIDTH(32), .RD_LAT(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .error(error[1]), .base_addr(base_addr), .max_len(max_len), .char_re(char_re[1]),
    .char_addr(char_addr[1]), .char_rdata(char_rdata[1]), .value(val_b), .n_chars(n_chars[1])
  );

  osd_sdec_reader #(.WIDTH(8), .RD_LAT(1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .busy(busy[2]), .done(done[2]),
    .error(error[2]), .base_addr(base_addr), .max_len(max_len), .char_re(char_re[2]),
    .char_addr(char_addr[2]), .char_rdata(char_rdata[2]), .value(val_c), .n_chars(n_chars[2])
  );

  // Char RAM read pipeline; data outside the valid slot reads as '?' (a terminator)
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      pv[d][0] <= char_re[d];
      pa[d][0] <= char_addr[d];
      for (int k = 1; k < 3; k++) begin
        pv[d][k] <= pv[d][k-1];
        pa[d][k] <= pa[d][k-1];
      end
    end
  end

  assign char_rdata[0] = pv[0][0] ? mem[pa[0][0]] : 8'h3F;
  assign char_rdata[1] = pv[1][2] ? mem[pa[1][2]] : 8'h3F;
  assign char_rdata[2] = pv[2][0] ? mem[pa[2][0]] : 8'h3F;

  function automatic int latOf(input int d);
    return (d == 1) ? 3 : 1;
  endfunction

  function automatic int widthOf(input int d);
    return (d == 2) ? 8 : 32;
  endfunction

  function automatic longint getVal(input int d);
    case (d)
      0:       return longint'($signed(val_a));
      1:       return longint'($signed(val_b));
      default: return longint'($signed(val_c));
    endcase
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic loadText(input int base, input string text);
    for (int i = 0; i < text.len(); i++) begin
      mem[16'(base + i)] = text[i];
    end
    mem[16'(base + text.len())] = 8'h00;
  endtask

  function automatic logic [7:0] randChar();
    string alpha = " +-0123456789X";
    int k = $urandom_range(0, 14);
    if (k == 14) return 8'h00;
    return alpha[k];
  endfunction

  // Reference parser straight from the character rules, using wide integer arithmetic
  task automatic refParse(input int base, input int ml, input int w, output longint val,
                          output longint err, output longint nch, output longint reads);
    int phase = 0;
    bit neg = 0;
    bit seen = 0;
    longint mag = 0;
    longint limit;
    logic [7:0] c;
    val = 0; err = 0; nch = 0; reads = 0;
    if (ml == 0) begin
      err = 1;
      return;
    end
    for (int i = 0; i < ml; i++) begin
      c = mem[16'(base + i)];
      reads++;
      if (c >= "0" && c <= "9") begin
        mag = mag * 10 + longint'(c - 8'h30);
        seen = 1;
        phase = 2;
        nch++;
        limit = (longint'(1) << (w - 1)) - (neg ? 0 : 1);
        if (mag > limit) begin
          err = 1;
          val = neg ? -limit : limit;
          return;
        end
      end else if (c == " " && phase == 0) begin
        nch++;
      end else if ((c == "+" || c == "-") && phase == 0) begin
        neg = (c == "-");
        phase = 1;
        nch++;
      end else begin
        break;
      end
    end
    if (!seen) begin
      err = 1;
      val = 0;
    end else begin
      val = neg ? -mag : mag;
    end
  endtask

  // One parse: start pulse, count cycles/reads until done, then watch for stray activity
  task automatic applyStimulus(input int d, input int base, input int ml, input bit poke,
                               output res_t r);
    bit finished = 0;
    int cyc = 1;
    r = '{default: 0};
    @(negedge clk);
    base_addr = 16'(base);
    max_len = 8'(ml);
    start[d] = 1'b1;
    while (!finished && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (char_re[d]) begin
        if (r.reads == 0) r.a0 = char_addr[d];
        if (r.reads == 1) r.a1 = char_addr[d];
        r.reads++;
      end
      if (done[d]) begin
        finished = 1;
        r.busyAtDone = busy[d];
        r.val = getVal(d);
        r.err = error[d];
        r.nch = n_chars[d];
      end
      start[d] = poke && (finished || (cyc % 2 == 1));
    end
    r.cyc = finished ? cyc : -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start[d] = 1'b0;
      if (done[d] || busy[d]) r.extra++;
    end
  endtask

  task automatic checkResult(input string tag, input int d, input res_t r, input longint ev,
                             input longint ee, input longint en, input longint er);
    checkOutput($sformatf("%s value", tag), r.val, ev);
    checkOutput($sformatf("%s error", tag), r.err, ee);
    checkOutput($sformatf("%s n_chars", tag), r.nch, en);
    checkOutput($sformatf("%s reads", tag), r.reads, er);
    checkOutput($sformatf("%s done_cycle", tag), r.cyc, 1 + er * (latOf(d) + 1) + 1);
    checkOutput($sformatf("%s busy_at_done", tag), r.busyAtDone, 0);
    checkOutput($sformatf("%s stray_activity", tag), r.extra, 0);
  endtask

  initial begin
    vec_t vecs[$];
    res_t r;
    int cyc;
    int seenDone;
    int base;
    int ml;
    int pos;
    longint ev, ee, en, er;

    rst_n = 1'b0;
    base_addr = 16'h0000;
    max_len = 8'd0;
    for (int d = 0; d < 3; d++) start[d] = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    vecs.push_back('{0, 'h0100, 10, "  -1234 ", -1234, 0, 7, 8});
    vecs.push_back('{1, 'h0100, 10, "  -1234 ", -1234, 0, 7, 8});
    vecs.push_back('{0, 'h0200, 8, "+007X", 7, 0, 4, 5});
    vecs.push_back('{1, 'h0200, 8, "+007X", 7, 0, 4, 5});
    vecs.push_back('{0, 'h0210, 1, "5", 5, 0, 1, 1});
    vecs.push_back('{1, 'h0210, 1, "5", 5, 0, 1, 1});
    vecs.push_back('{2, 'h0220, 3, "127", 127, 0, 3, 3});
    vecs.push_back('{2, 'h0230, 4, "-128", -128, 0, 4, 4});
    vecs.push_back('{2, 'h0240, 3, "128", 127, 1, 3, 3});
    vecs.push_back('{2, 'h0250, 4, "-129", -128, 1, 4, 4});
    vecs.push_back('{0, 'h0260, 6, "   -", 0, 1, 4, 5});
    vecs.push_back('{1, 'h0260, 6, "   -", 0, 1, 4, 5});
    vecs.push_back('{0, 'h0270, 10, "-0 ", 0, 0, 2, 3});
    vecs.push_back('{0, 'h0280, 0, "99", 0, 1, 0, 0});
    vecs.push_back('{1, 'h0280, 0, "99", 0, 1, 0, 0});
    vecs.push_back('{0, 'h0290, 12, "2147483647X", 64'sd2147483647, 0, 10, 11});
    vecs.push_back('{0, 'h02A0, 12, "-2147483648 ", -64'sd2147483648, 0, 11, 12});
    vecs.push_back('{0, 'h02B0, 12, "2147483648", 64'sd2147483647, 1, 10, 10});
    vecs.push_back('{2, 'h02C0, 10, "0000127;", 127, 0, 7, 8});
    vecs.push_back('{0, 'h02D0, 2, " 12 ", 1, 0, 2, 2});
    vecs.push_back('{1, 'h02E0, 5, "+-5", 0, 1, 1, 2});

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("reset d%0d busy", d), busy[d], 0);
      checkOutput($sformatf("reset d%0d done", d), done[d], 0);
      checkOutput($sformatf("reset d%0d error", d), error[d], 0);
      checkOutput($sformatf("reset d%0d char_re", d), char_re[d], 0);
      checkOutput($sformatf("reset d%0d char_addr", d), char_addr[d], 0);
      checkOutput($sformatf("reset d%0d value", d), getVal(d), 0);
      checkOutput($sformatf("reset d%0d n_chars", d), n_chars[d], 0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      loadText(vecs[i].base, vecs[i].text);
      applyStimulus(vecs[i].d, vecs[i].base, vecs[i].ml, 1'b0, r);
      checkResult($sformatf("vec%0d", i), vecs[i].d, r, vecs[i].expVal, vecs[i].expErr,
                  vecs[i].expN, vecs[i].expReads);
    end

    // Address wrap with start pulses while busy and in the done cycle
    loadText('hFFFF, "12");
    applyStimulus(1, 'hFFFF, 5, 1'b1, r);
    checkResult("wrap", 1, r, 12, 0, 2, 3);
    checkOutput("wrap addr0", r.a0, 'hFFFF);
    checkOutput("wrap addr1", r.a1, 'h0000);

    // Reset during the wait of the third character
    loadText('h0300, "  -1234 ");
    @(negedge clk);
    base_addr = 16'h0300;
    max_len = 8'd10;
    start[1] = 1'b1;
    cyc = 1;
    repeat (10) begin
      @(negedge clk);
      start[1] = 1'b0;
      cyc++;
    end
    checkOutput("pre-reset busy", busy[1], 1);
    checkOutput("pre-reset char_re", char_re[1], 0);
    checkOutput("pre-reset n_chars", n_chars[1], 2);
    rst_n = 1'b0;
    #1;
    checkOutput("mid-reset busy", busy[1], 0);
    checkOutput("mid-reset done", done[1], 0);
    checkOutput("mid-reset error", error[1], 0);
    checkOutput("mid-reset char_re", char_re[1], 0);
    checkOutput("mid-reset char_addr", char_addr[1], 0);
    checkOutput("mid-reset value", getVal(1), 0);
    checkOutput("mid-reset n_chars", n_chars[1], 0);
    seenDone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done[1]) seenDone++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done[1] || busy[1]) seenDone++;
    end
    checkOutput("aborted op done", seenDone, 0);
    loadText('h0400, "+42 ");
    applyStimulus(1, 'h0400, 6, 1'b0, r);
    checkResult("post-reset", 1, r, 42, 0, 3, 4);

    // Random strings against the reference parser
    for (int d = 0; d < 3; d++) begin
      for (int it = 0; it < 25; it++) begin
        base = $urandom_range(0, 65535);
        ml = $urandom_range(0, 14);
        pos = 0;
        for (int i = 0; i < 16; i++) mem[16'(base + i)] = randChar();
        repeat ($urandom_range(0, 3)) begin
          mem[16'(base + pos)] = " ";
          pos++;
        end
        if ($urandom_range(0, 1) == 1) begin
          mem[16'(base + pos)] = ($urandom_range(0, 1) == 1) ? "-" : "+";
          pos++;
        end
        repeat ($urandom_range(0, (d == 2) ? 4 : 11)) begin
          mem[16'(base + pos)] = 8'(8'h30 + $urandom_range(0, 9));
          pos++;
        end
        if ($urandom_range(0, 3) == 0) mem[16'(base + $urandom_range(0, 15))] = randChar();
        refParse(base, ml, widthOf(d), ev, ee, en, er);
        applyStimulus(d, base, ml, (it % 5 == 0), r);
        checkResult($sformatf("rnd d%0d #%0d", d, it), d, r, ev, ee, en, er);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
